// File: rtl/format_scan_multilane.sv
// rtl/format_scan_multilane.sv - multi-lane primary-opcode format classifier with 2-entry skid FIFO
module format_scan_multilane #(
    parameter int LANES                   = 2,
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 6,
    parameter int formatWidth             = 26,
    parameter int statWidth               = 32
) (
    input  logic                                       clock_i,
    input  logic                                       reset_i,
    input  logic                                       flush_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    input  logic [LANES-1:0]                           laneValid_i,
    input  logic [LANES*instructionWidth-1:0]          instruction_i,
    input  logic [addressWidth-1:0]                    instructionAddress_i,
    input  logic [PidSize-1:0]                         instructionPid_i,
    input  logic [TidSize-1:0]                         instructionTid_i,
    input  logic [instructionCounterWidth-1:0]         instructionMajId_i,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    output logic [LANES-1:0]                           laneValid_o,
    output logic [LANES-1:0]                           invalidOp_o,
    output logic [LANES*formatWidth-1:0]               instFormat_o,
    output logic [LANES*opcodeSize-1:0]                instOpcode_o,
    output logic [LANES*instructionWidth-1:0]          instruction_o,
    output logic [LANES*addressWidth-1:0]              instructionAddress_o,
    output logic [PidSize-1:0]                         instructionPid_o,
    output logic [TidSize-1:0]                         instructionTid_o,
    output logic [LANES*instructionCounterWidth-1:0]   instructionMajId_o,
    output logic [instructionCounterWidth-1:0]         decodedCount_o,
    output logic [statWidth-1:0]                       invalidCount_o
);

    localparam logic [formatWidth-1:0] F_ONE = 1;
    localparam logic [formatWidth-1:0] F_A   = F_ONE << 0;
    localparam logic [formatWidth-1:0] F_B   = F_ONE << 1;
    localparam logic [formatWidth-1:0] F_D   = F_ONE << 2;
    localparam logic [formatWidth-1:0] F_DQ  = F_ONE << 3;
    localparam logic [formatWidth-1:0] F_DS  = F_ONE << 4;
    localparam logic [formatWidth-1:0] F_DX  = F_ONE << 5;
    localparam logic [formatWidth-1:0] F_I   = F_ONE << 6;
    localparam logic [formatWidth-1:0] F_M   = F_ONE << 7;
    localparam logic [formatWidth-1:0] F_MD  = F_ONE << 8;
    localparam logic [formatWidth-1:0] F_MDS = F_ONE << 9;
    localparam logic [formatWidth-1:0] F_SC  = F_ONE << 10;
    localparam logic [formatWidth-1:0] F_VA  = F_ONE << 11;
    localparam logic [formatWidth-1:0] F_VC  = F_ONE << 12;
    localparam logic [formatWidth-1:0] F_VX  = F_ONE << 13;
    localparam logic [formatWidth-1:0] F_X   = F_ONE << 14;
    localparam logic [formatWidth-1:0] F_XFL = F_ONE << 15;
    localparam logic [formatWidth-1:0] F_XFX = F_ONE << 16;
    localparam logic [formatWidth-1:0] F_XL  = F_ONE << 17;
    localparam logic [formatWidth-1:0] F_XO  = F_ONE << 18;
    localparam logic [formatWidth-1:0] F_XS  = F_ONE << 19;
    localparam logic [formatWidth-1:0] F_XX2 = F_ONE << 20;
    localparam logic [formatWidth-1:0] F_XX3 = F_ONE << 21;
    localparam logic [formatWidth-1:0] F_Z22 = F_ONE << 23;
    localparam logic [formatWidth-1:0] F_Z23 = F_ONE << 24;

    // An all-zero mask doubles as the "unrecognised opcode" indication.
    function automatic logic [formatWidth-1:0] decode_op(input logic [opcodeSize-1:0] op);
        logic [formatWidth-1:0] m;
        m = '0;
        case (int'(op)) inside
            2, 3, 7, 8, [10:15], [24:29], [32:55]: m = F_D;
            4:                m = F_VA | F_VX | F_VC;
            16:               m = F_B;
            17:               m = F_SC;
            18:               m = F_I;
            19:               m = F_XL | F_DX;
            20, 21, 23:       m = F_M;
            30:               m = F_MD | F_MDS;
            31:               m = F_X | F_XO | F_Z23 | F_A | F_XS | F_XFX;
            56:               m = F_DQ;
            57, 58, 61, 62:   m = F_DS;
            59:               m = F_A | F_X | F_Z22 | F_Z23;
            60:               m = F_XX2 | F_XX3;
            63:               m = F_A | F_X | F_XFL | F_Z22 | F_Z23;
            default:          m = '0;
        endcase
        return m;
    endfunction

    logic [LANES-1:0]                   mem_lv    [2];
    logic [LANES*instructionWidth-1:0]  mem_instr [2];
    logic [addressWidth-1:0]            mem_addr  [2];
    logic [PidSize-1:0]                 mem_pid   [2];
    logic [TidSize-1:0]                 mem_tid   [2];
    logic [instructionCounterWidth-1:0] mem_maj   [2];

    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic       ready_q;
    logic       push;
    logic       pop;
    logic       head_valid;

    logic [instructionCounterWidth-1:0] decoded_q;
    logic [statWidth-1:0]               invalid_q;

    assign head_valid = (count_q != 2'd0);
    assign valid_o    = head_valid;
    assign ready_o    = ready_q;

    // Flush dominates both sides of the handshake.
    always_comb begin
        push    = valid_i && ready_q && !flush_i;
        pop     = head_valid && ready_i && !flush_i;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
        end else if (flush_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Payload storage needs no reset: outputs are gated by head_valid.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_lv[wr_ptr_q]    <= laneValid_i;
            mem_instr[wr_ptr_q] <= instruction_i;
            mem_addr[wr_ptr_q]  <= instructionAddress_i;
            mem_pid[wr_ptr_q]   <= instructionPid_i;
            mem_tid[wr_ptr_q]   <= instructionTid_i;
            mem_maj[wr_ptr_q]   <= instructionMajId_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            decoded_q <= '0;
            invalid_q <= '0;
        end else if (pop) begin
            decoded_q <= decoded_q + instructionCounterWidth'($countones(laneValid_o));
            invalid_q <= invalid_q + statWidth'($countones(invalidOp_o));
        end
    end

    assign decodedCount_o = decoded_q;
    assign invalidCount_o = invalid_q;

    always_comb begin
        logic [opcodeSize-1:0]  op;
        logic [formatWidth-1:0] raw;
        logic [LANES-1:0]       lv;
        op                   = '0;
        raw                  = '0;
        lv                   = mem_lv[rd_ptr_q];
        laneValid_o          = '0;
        invalidOp_o          = '0;
        instFormat_o         = '0;
        instOpcode_o         = '0;
        instruction_o        = '0;
        instructionAddress_o = '0;
        instructionPid_o     = '0;
        instructionTid_o     = '0;
        instructionMajId_o   = '0;
        if (head_valid) begin
            laneValid_o      = lv;
            instruction_o    = mem_instr[rd_ptr_q];
            instructionPid_o = mem_pid[rd_ptr_q];
            instructionTid_o = mem_tid[rd_ptr_q];
            for (int k = 0; k < LANES; k++) begin
                op  = mem_instr[rd_ptr_q][k*instructionWidth + instructionWidth - opcodeSize +: opcodeSize];
                raw = decode_op(op);
                instOpcode_o[k*opcodeSize +: opcodeSize] = op;
                instFormat_o[k*formatWidth +: formatWidth] = lv[k] ? raw : '0;
                invalidOp_o[k] = lv[k] && (raw == '0);
                instructionAddress_o[k*addressWidth +: addressWidth] =
                    mem_addr[rd_ptr_q] + addressWidth'(4 * k);
                instructionMajId_o[k*instructionCounterWidth +: instructionCounterWidth] =
                    mem_maj[rd_ptr_q] + instructionCounterWidth'(k);
            end
        end
    end

endmodule

// File: tb/tb_format_scan_multilane.sv
// tb/tb_format_scan_multilane.sv - scoreboard bench for format_scan_multilane
module tb_format_scan_multilane;

    localparam int L  = 2;
    localparam int IW = 32;
    localparam int AW = 64;
    localparam int PW = 20;
    localparam int TW = 16;
    localparam int CW = 64;
    localparam int OW = 6;
    localparam int FW = 26;
    localparam int SW = 32;

    localparam int FB_A = 0, FB_B = 1, FB_D = 2, FB_DQ = 3, FB_DS = 4, FB_DX = 5, FB_I = 6;
    localparam int FB_M = 7, FB_MD = 8, FB_MDS = 9, FB_SC = 10, FB_VA = 11, FB_VC = 12, FB_VX = 13;
    localparam int FB_X = 14, FB_XFL = 15, FB_XFX = 16, FB_XL = 17, FB_XO = 18, FB_XS = 19;
    localparam int FB_XX2 = 20, FB_XX3 = 21, FB_Z22 = 23, FB_Z23 = 24;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    logic flush_i = 1'b0;
    logic valid_i = 1'b0;
    logic ready_o;
    logic [L-1:0]    laneValid_i = '0;
    logic [L*IW-1:0] instruction_i = '0;
    logic [AW-1:0]   instructionAddress_i = '0;
    logic [PW-1:0]   instructionPid_i = '0;
    logic [TW-1:0]   instructionTid_i = '0;
    logic [CW-1:0]   instructionMajId_i = '0;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [L-1:0]    laneValid_o;
    logic [L-1:0]    invalidOp_o;
    logic [L*FW-1:0] instFormat_o;
    logic [L*OW-1:0] instOpcode_o;
    logic [L*IW-1:0] instruction_o;
    logic [L*AW-1:0] instructionAddress_o;
    logic [PW-1:0]   instructionPid_o;
    logic [TW-1:0]   instructionTid_o;
    logic [L*CW-1:0] instructionMajId_o;
    logic [CW-1:0]   decodedCount_o;
    logic [SW-1:0]   invalidCount_o;

    format_scan_multilane #(.LANES(L)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .laneValid_i(laneValid_i), .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
        .instructionPid_i(instructionPid_i), .instructionTid_i(instructionTid_i),
        .instructionMajId_i(instructionMajId_i), .valid_o(valid_o), .ready_i(ready_i),
        .laneValid_o(laneValid_o), .invalidOp_o(invalidOp_o), .instFormat_o(instFormat_o),
        .instOpcode_o(instOpcode_o), .instruction_o(instruction_o),
        .instructionAddress_o(instructionAddress_o), .instructionPid_o(instructionPid_o),
        .instructionTid_o(instructionTid_o), .instructionMajId_o(instructionMajId_o),
        .decodedCount_o(decodedCount_o), .invalidCount_o(invalidCount_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [L-1:0]    lv;
        logic [L-1:0]    inv;
        logic [L*FW-1:0] fmt;
        logic [L*OW-1:0] op;
        logic [L*IW-1:0] ins;
        logic [L*AW-1:0] addr;
        logic [PW-1:0]   pid;
        logic [TW-1:0]   tid;
        logic [L*CW-1:0] maj;
    } exp_t;

    exp_t          sb[$];
    logic [FW-1:0] fmt_tab [64];
    logic [CW-1:0] exp_dec = '0;
    logic [SW-1:0] exp_inv = '0;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [FW-1:0] fb(input int n);
        logic [FW-1:0] one;
        one = 1;
        return one << n;
    endfunction

    function automatic void build_tab();
        for (int i = 0; i < 64; i++) begin
            fmt_tab[i] = '0;
            if (i == 2 || i == 3 || i == 7 || i == 8 || (i >= 10 && i <= 15) ||
                (i >= 24 && i <= 29) || (i >= 32 && i <= 55))
                fmt_tab[i] = fb(FB_D);
        end
        fmt_tab[4]  = fb(FB_VA) | fb(FB_VX) | fb(FB_VC);
        fmt_tab[16] = fb(FB_B);
        fmt_tab[17] = fb(FB_SC);
        fmt_tab[18] = fb(FB_I);
        fmt_tab[19] = fb(FB_XL) | fb(FB_DX);
        fmt_tab[20] = fb(FB_M);
        fmt_tab[21] = fb(FB_M);
        fmt_tab[23] = fb(FB_M);
        fmt_tab[30] = fb(FB_MD) | fb(FB_MDS);
        fmt_tab[31] = fb(FB_X) | fb(FB_XO) | fb(FB_Z23) | fb(FB_A) | fb(FB_XS) | fb(FB_XFX);
        fmt_tab[56] = fb(FB_DQ);
        fmt_tab[57] = fb(FB_DS);
        fmt_tab[58] = fb(FB_DS);
        fmt_tab[61] = fb(FB_DS);
        fmt_tab[62] = fb(FB_DS);
        fmt_tab[59] = fb(FB_A) | fb(FB_X) | fb(FB_Z22) | fb(FB_Z23);
        fmt_tab[60] = fb(FB_XX2) | fb(FB_XX3);
        fmt_tab[63] = fb(FB_A) | fb(FB_X) | fb(FB_XFL) | fb(FB_Z22) | fb(FB_Z23);
    endfunction

    function automatic exp_t model(input logic [L-1:0] lv, input logic [L*IW-1:0] ins,
                                   input logic [AW-1:0] addr, input logic [PW-1:0] pid,
                                   input logic [TW-1:0] tid, input logic [CW-1:0] maj);
        exp_t e;
        logic [IW-1:0] w;
        int opc;
        e.lv = lv; e.ins = ins; e.pid = pid; e.tid = tid;
        e.inv = '0; e.fmt = '0; e.op = '0; e.addr = '0; e.maj = '0;
        for (int k = 0; k < L; k++) begin
            w   = ins[k*IW +: IW];
            opc = int'(w / (1 << 26));
            e.op[k*OW +: OW]   = OW'(opc);
            e.fmt[k*FW +: FW]  = lv[k] ? fmt_tab[opc] : '0;
            e.inv[k]           = lv[k] && (fmt_tab[opc] == '0);
            e.addr[k*AW +: AW] = addr + AW'(4 * k);
            e.maj[k*CW +: CW]  = maj + CW'(k);
        end
        return e;
    endfunction

    // Monitor: compares the head of the scoreboard and retires it on delivery.
    always @(negedge clock_i) begin
        if (reset_i) begin
            sb.delete();
            exp_dec = '0;
            exp_inv = '0;
        end else begin
            chk("valid_o", valid_o, sb.size() != 0);
            chk("ready_o", ready_o, sb.size() < 2);
            chk("decodedCount", decodedCount_o, exp_dec);
            chk("invalidCount", invalidCount_o, exp_inv);
            if (valid_o && sb.size() != 0) begin
                chk("laneValid_o", laneValid_o, sb[0].lv);
                chk("invalidOp_o", invalidOp_o, sb[0].inv);
                chk("instFormat_o", instFormat_o, sb[0].fmt);
                chk("instOpcode_o", instOpcode_o, sb[0].op);
                chk("instruction_o", instruction_o, sb[0].ins);
                chk("address_o", instructionAddress_o, sb[0].addr);
                chk("pid_o", instructionPid_o, sb[0].pid);
                chk("tid_o", instructionTid_o, sb[0].tid);
                chk("majid_o", instructionMajId_o, sb[0].maj);
            end
            if (flush_i) begin
                sb.delete();
            end else if (valid_o && ready_i && sb.size() != 0) begin
                exp_dec = exp_dec + CW'($countones(sb[0].lv));
                exp_inv = exp_inv + SW'($countones(sb[0].inv));
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [L-1:0] lv, input logic [L*IW-1:0] ins,
                        input logic [AW-1:0] addr, input logic [PW-1:0] pid, input logic [TW-1:0] tid,
                        input logic [CW-1:0] maj, input logic fl, input logic rdy, output logic acc);
        @(posedge clock_i);
        #1;
        valid_i = v; laneValid_i = lv; instruction_i = ins; instructionAddress_i = addr;
        instructionPid_i = pid; instructionTid_i = tid; instructionMajId_i = maj;
        flush_i = fl; ready_i = rdy;
        @(negedge clock_i);
        #1;
        acc = v && ready_o && !fl && !reset_i;
        if (acc) sb.push_back(model(lv, ins, addr, pid, tid, maj));
    endtask

    task automatic idle(input logic rdy);
        logic a;
        step(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, rdy, a);
    endtask

    task automatic send(input logic [L-1:0] lv, input logic [L*IW-1:0] ins, input logic rdy);
        logic a;
        logic [AW-1:0] addr;
        logic [CW-1:0] maj;
        int n;
        addr = {$urandom, $urandom};
        maj  = {$urandom, $urandom};
        n = 0;
        a = 1'b0;
        while (!a && n < 20) begin
            step(1'b1, lv, ins, addr, PW'($urandom), TW'($urandom), maj, 1'b0, rdy, a);
            n++;
        end
        if (!a) chk("send_timeout", 0, 1);
    endtask

    function automatic logic [L*IW-1:0] rand_ins();
        logic [L*IW-1:0] r;
        for (int k = 0; k < L; k++) r[k*IW +: IW] = $urandom;
        return r;
    endfunction

    initial begin
        logic a;
        int n;
        logic [CW-1:0] dec_b;
        logic [SW-1:0] inv_b;
        build_tab();
        #2 reset_i = 1'b1;
        repeat (2) @(posedge clock_i);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_dec", decodedCount_o, 0);
        chk("rst_inv", invalidCount_o, 0);
        chk("rst_fmt", instFormat_o, 0);
        chk("rst_addr", instructionAddress_o, 0);
        reset_i = 1'b0;

        // Basic decode: op18 and op31.
        step(1'b1, 2'b11, {32'h7C0802A6, 32'h48000010}, 64'h1000, 20'h5, 16'h7, 64'd100, 1'b0, 1'b1, a);
        chk("t1_accept", a, 1);
        idle(1'b1);
        chk("t1_fmt", instFormat_o, {26'h10D4001, 26'h0000040});
        chk("t1_addr", instructionAddress_o, {64'h1004, 64'h1000});
        chk("t1_maj", instructionMajId_o, {64'd101, 64'd100});
        idle(1'b1);
        chk("t1_dec", decodedCount_o, 2);

        // Unrecognised opcode on lane 1.
        step(1'b1, 2'b11, {32'h04000000, 32'h48000010}, 64'h2000, 20'h1, 16'h2, 64'd7, 1'b0, 1'b1, a);
        idle(1'b1);
        chk("t2_invop", invalidOp_o, 2'b10);
        chk("t2_fmt", instFormat_o, {26'h0, 26'h0000040});
        idle(1'b1);
        chk("t2_inv", invalidCount_o, 1);
        chk("t2_dec", decodedCount_o, 4);

        // Back-pressure: third group held until release.
        send(2'b11, rand_ins(), 1'b0);
        send(2'b01, rand_ins(), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b10, {32'hF8000000, 32'h7C000000}, 64'h3000, 20'h3, 16'h3, 64'd3, 1'b0, 1'b0, a);
            chk("t3_held", a, 0);
        end
        send(2'b10, {32'hF8000000, 32'h7C000000}, 1'b1);
        repeat (4) idle(1'b1);

        // Full FIFO streaming with ready_i=1.
        send(2'b11, rand_ins(), 1'b0);
        send(2'b11, rand_ins(), 1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'($urandom), rand_ins(), {$urandom, $urandom}, PW'($urandom), TW'($urandom),
                 {$urandom, $urandom}, 1'b0, 1'b1, a);
            if (a) n++;
        end
        chk("t4_accepts", n, 9);
        repeat (4) idle(1'b1);

        // Flush with two buffered groups and a concurrent push.
        send(2'b11, rand_ins(), 1'b0);
        send(2'b11, rand_ins(), 1'b0);
        dec_b = decodedCount_o;
        inv_b = invalidCount_o;
        step(1'b1, 2'b11, rand_ins(), 64'h0, 20'h0, 16'h0, 64'h0, 1'b1, 1'b1, a);
        idle(1'b0);
        chk("t5_valid", valid_o, 0);
        chk("t5_ready", ready_o, 1);
        chk("t5_dec", decodedCount_o, dec_b);
        chk("t5_inv", invalidCount_o, inv_b);

        // Asynchronous reset with a full FIFO.
        send(2'b11, rand_ins(), 1'b0);
        send(2'b11, rand_ins(), 1'b0);
        @(posedge clock_i);
        #3;
        valid_i = 1'b0;
        reset_i = 1'b1;
        #1;
        chk("t6_valid", valid_o, 0);
        chk("t6_ready", ready_o, 1);
        chk("t6_dec", decodedCount_o, 0);
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), rand_ins(), {$urandom, $urandom},
                 PW'($urandom), TW'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, a);
        end

        n = 0;
        while ((sb.size() != 0 || valid_o) && n < 20) begin
            idle(1'b1);
            n++;
        end
        chk("drain", sb.size(), 0);
        idle(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
